multi_lane_message_counter: RTL and testbench

//  Parametrised successor to the single-lane message counter. Emits LANES consecutive 64-bit

---
 rtl/multi_lane_message_counter.sv | 157 +++++++++++++++
 tb/tb_multi_lane_message_counter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_message_counter.sv
// multi_lane_message_counter
// Emits LANES consecutive 64-bit messages {counter, region} per beat over a
// valid/ready handshake. Counts from 0 up to an inclusive limit, then raises done.
// Optional feature: define MSGGEN_PROGRESS_EN to add the beat_count output,
// which counts beats fired since the last accepted start.
module multi_lane_message_counter #(
  parameter int N         = 32,  // region-select width, counter width W = 64-N
  parameter int LANES     = 4,   // messages per beat, power of 2
  parameter int LANE_BITS = 2    // log2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic [N-1:0]          region_select,
  input  logic [63-N:0]         counter_limit,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [LANES-1:0]      out_lane_valid,
  output logic [64*LANES-1:0]   out_msgs,
  output logic                  busy,
  output logic                  done
`ifdef MSGGEN_PROGRESS_EN
  ,
  output logic [63-N:0]         beat_count
`endif
);

  localparam int W = 64 - N;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_reg;
  logic [W-1:0]          base_reg, base_next;
  logic [N-1:0]          region_reg, region_next;
  logic [W-1:0]          limit_reg, limit_next;
  logic                  out_valid_reg;
  logic [LANES-1:0]      lane_valid_reg;
  logic [64*LANES-1:0]   msgs_reg;

  logic                  fire;
  logic                  start_ok;
  logic [W:0]            last_sum;
  logic                  last_beat;
  logic [LANES-1:0]      lane_valid_next;
  logic [64*LANES-1:0]   msgs_next;

  // Handshake decode and the next base/region/limit; one extra bit keeps the
  // last-beat compare free of wrap-around, even for a limit of 2^W-1.
  always_comb begin
    fire        = out_valid_reg & out_ready;
    start_ok    = start & ~clear & (state_reg == S_IDLE);
    last_sum    = {1'b0, base_reg} + (W+1)'(LANES - 1);
    last_beat   = (last_sum >= {1'b0, limit_reg});
    base_next   = base_reg;
    region_next = region_reg;
    limit_next  = limit_reg;
    if (start_ok) begin
      base_next   = '0;
      region_next = region_select;
      limit_next  = counter_limit;
    end else if (!clear && (state_reg == S_RUN) && fire && !last_beat) begin
      base_next   = base_reg + (W'(1) << LANE_BITS);
    end
  end

  // Per-lane counter value and validity for the beat that the registers will hold next.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W:0] lane_sum;
      assign lane_sum                  = {1'b0, base_next} + (W+1)'(gi);
      assign lane_valid_next[gi]       = (lane_sum <= {1'b0, limit_next});
      assign msgs_next[64*gi +: 64]    = {lane_sum[W-1:0], region_next};
    end
  endgenerate

  // Control FSM with registered handshake outputs; clear overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      base_reg       <= '0;
      region_reg     <= '0;
      limit_reg      <= '0;
      out_valid_reg  <= 1'b0;
      lane_valid_reg <= '0;
      msgs_reg       <= '0;
    end else begin
      base_reg   <= base_next;
      region_reg <= region_next;
      limit_reg  <= limit_next;
      msgs_reg   <= msgs_next;
      if (clear) begin
        state_reg      <= S_IDLE;
        out_valid_reg  <= 1'b0;
        lane_valid_reg <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              state_reg      <= S_RUN;
              out_valid_reg  <= 1'b1;
              lane_valid_reg <= lane_valid_next;
            end
          end
          S_RUN: begin
            if (fire) begin
              if (last_beat) begin
                state_reg      <= S_DONE;
                out_valid_reg  <= 1'b0;
                lane_valid_reg <= '0;
              end else begin
                lane_valid_reg <= lane_valid_next;
              end
            end
          end
          S_DONE: begin
            state_reg <= S_DONE;
          end
          default: begin
            state_reg      <= S_IDLE;
            out_valid_reg  <= 1'b0;
            lane_valid_reg <= '0;
          end
        endcase
      end
    end
  end

`ifdef MSGGEN_PROGRESS_EN
  logic [W-1:0] beat_count_reg;

  // Beats fired since the last accepted start; frozen once the run is done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_count_reg <= '0;
    end else if (clear || start_ok) begin
      beat_count_reg <= '0;
    end else if ((state_reg == S_RUN) && fire) begin
      beat_count_reg <= beat_count_reg + W'(1);
    end
  end

  assign beat_count = beat_count_reg;
`endif

  assign out_valid      = out_valid_reg;
  assign out_lane_valid = lane_valid_reg;
  assign out_msgs       = msgs_reg;
  assign busy           = (state_reg == S_RUN);
  assign done           = (state_reg == S_DONE);

endmodule

// File: tb/tb_multi_lane_message_counter.sv
// Directed testbench for multi_lane_message_counter: one N=32 instance and one
// N=60 (W=4) instance, LANES=4 each. Define MSGGEN_PROGRESS_EN to cover beat_count.
module tb_multi_lane_message_counter;

  logic clk;
  logic rst_n;

  // N=32 instance
  logic         a_start, a_clear, a_ready;
  logic [31:0]  a_region, a_limit;
  logic         a_valid, a_busy, a_done;
  logic [3:0]   a_lv;
  logic [255:0] a_msgs;
`ifdef MSGGEN_PROGRESS_EN
  logic [31:0]  a_bc;
`endif

  // N=60 instance
  logic         b_start, b_clear, b_ready;
  logic [59:0]  b_region;
  logic [3:0]   b_limit;
  logic         b_valid, b_busy, b_done;
  logic [3:0]   b_lv;
  logic [255:0] b_msgs;
`ifdef MSGGEN_PROGRESS_EN
  logic [3:0]   b_bc;
`endif

  int checks = 0;
  int errors = 0;

  multi_lane_message_counter #(.N(32), .LANES(4), .LANE_BITS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .clear(a_clear),
    .region_select(a_region), .counter_limit(a_limit), .out_ready(a_ready),
    .out_valid(a_valid), .out_lane_valid(a_lv), .out_msgs(a_msgs),
    .busy(a_busy), .done(a_done)
`ifdef MSGGEN_PROGRESS_EN
    , .beat_count(a_bc)
`endif
  );

  multi_lane_message_counter #(.N(60), .LANES(4), .LANE_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .clear(b_clear),
    .region_select(b_region), .counter_limit(b_limit), .out_ready(b_ready),
    .out_valid(b_valid), .out_lane_valid(b_lv), .out_msgs(b_msgs),
    .busy(b_busy), .done(b_done)
`ifdef MSGGEN_PROGRESS_EN
    , .beat_count(b_bc)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [31:0] region, input logic [31:0] limit);
    a_region = region;
    a_limit  = limit;
    a_start  = 1'b1;
    step();
    a_start  = 1'b0;
  endtask

  task automatic clear_a();
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    checks++; if (a_lv !== 4'b0) begin errors++; $display("FAIL reset_lane_valid: got %b want 0000", a_lv); end
    checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", a_busy, a_done); end
    checks++; if (b_valid !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL reset_b: got %b%b%b want 000", b_valid, b_busy, b_done); end
    rst_n = 1'b1;
    step();
    checks++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b%b want 00", a_valid, a_busy); end
  endtask

  // T1: limit 0 -> a single beat with only lane 0 valid.
  task automatic test_single_beat();
    a_ready = 1'b1;
    start_a(32'hA5A5A5A5, 32'd0);
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b want 1", a_valid); end
    checks++; if (a_lv !== 4'b0001) begin errors++; $display("FAIL t1_mask: got %b want 0001", a_lv); end
    checks++; if (a_msgs[63:0] !== 64'h00000000_A5A5A5A5) begin errors++; $display("FAIL t1_lane0: got %h want 00000000a5a5a5a5", a_msgs[63:0]); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", a_busy); end
    step();
    checks++; if (a_valid !== 1'b0 || a_done !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL t1_done: got v=%b d=%b b=%b want 0 1 0", a_valid, a_done, a_busy); end
    clear_a();
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL t1_clear: got done=%b want 0", a_done); end
  endtask

  // T2: limit 9 with ready held high -> bases 0,4,8 and masks 1111,1111,0011.
  task automatic test_full_run();
    logic [31:0] bases [3];
    logic [3:0]  masks [3];
    bases = '{32'd0, 32'd4, 32'd8};
    masks = '{4'b1111, 4'b1111, 4'b0011};
    a_ready = 1'b1;
    start_a(32'h12345678, 32'd9);
    for (int k = 0; k < 3; k++) begin
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL t2_valid beat%0d: got %b want 1", k, a_valid); end
      checks++; if (a_lv !== masks[k]) begin errors++; $display("FAIL t2_mask beat%0d: got %b want %b", k, a_lv, masks[k]); end
      checks++; if (a_msgs[63:0] !== {bases[k], 32'h12345678}) begin errors++; $display("FAIL t2_lane0 beat%0d: got %h want %h", k, a_msgs[63:0], {bases[k], 32'h12345678}); end
      checks++; if (a_msgs[255:192] !== {bases[k] + 32'd3, 32'h12345678}) begin errors++; $display("FAIL t2_lane3 beat%0d: got %h want %h", k, a_msgs[255:192], {bases[k] + 32'd3, 32'h12345678}); end
      step();
    end
    checks++; if (a_valid !== 1'b0 || a_done !== 1'b1) begin errors++; $display("FAIL t2_done: got v=%b d=%b want 0 1", a_valid, a_done); end
    clear_a();
  endtask

  // T3: backpressure mid-run must freeze the beat with nothing skipped or repeated.
  task automatic test_stall();
    a_ready = 1'b0;
    start_a(32'hCAFEF00D, 32'd9);
    checks++; if (a_msgs[63:0] !== {32'd0, 32'hCAFEF00D}) begin errors++; $display("FAIL t3_first: got %h want 00000000cafef00d", a_msgs[63:0]); end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (a_valid !== 1'b1 || a_lv !== 4'b1111) begin errors++; $display("FAIL t3_stall_ctl cyc%0d: got v=%b m=%b want 1 1111", k, a_valid, a_lv); end
      checks++; if (a_msgs[63:0] !== {32'd4, 32'hCAFEF00D}) begin errors++; $display("FAIL t3_stall_msg cyc%0d: got %h want 00000004cafef00d", k, a_msgs[63:0]); end
      step();
    end
    a_ready = 1'b1;
    step();
    checks++; if (a_msgs[63:0] !== {32'd8, 32'hCAFEF00D} || a_lv !== 4'b0011) begin errors++; $display("FAIL t3_resume: got %h m=%b want 00000008cafef00d 0011", a_msgs[63:0], a_lv); end
    step();
    checks++; if (a_done !== 1'b1 || a_valid !== 1'b0) begin errors++; $display("FAIL t3_done: got d=%b v=%b want 1 0", a_done, a_valid); end
    clear_a();
  endtask

  // T4: W=4 with limit 15 -> four full beats, then done with no wrap to base 0.
  task automatic test_no_wrap();
    b_ready  = 1'b1;
    b_region = 60'h0ABCDEF01234567;
    b_limit  = 4'd15;
    b_start  = 1'b1;
    step();
    b_start  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (b_valid !== 1'b1 || b_lv !== 4'b1111) begin errors++; $display("FAIL t4_beat%0d_ctl: got v=%b m=%b want 1 1111", k, b_valid, b_lv); end
      checks++; if (b_msgs[63:0] !== {4'(4 * k), 60'h0ABCDEF01234567}) begin errors++; $display("FAIL t4_beat%0d_lane0: got %h want %h", k, b_msgs[63:0], {4'(4 * k), 60'h0ABCDEF01234567}); end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (b_valid !== 1'b0 || b_done !== 1'b1) begin errors++; $display("FAIL t4_done cyc%0d: got v=%b d=%b want 0 1", k, b_valid, b_done); end
      step();
    end
    b_clear = 1'b1;
    step();
    b_clear = 1'b0;
  endtask

  // T5: clear after the 2nd fire, restart with limit 3, start in DONE is ignored.
  task automatic test_clear_restart();
    a_ready = 1'b1;
    start_a(32'h0000BEEF, 32'd9);
    step();
    step();
    a_ready = 1'b0;
    a_clear = 1'b1;
    a_start = 1'b1;
    step();
    a_clear = 1'b0;
    a_start = 1'b0;
    checks++; if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL t5_cleared: got v=%b b=%b d=%b want 0 0 0", a_valid, a_busy, a_done); end
    start_a(32'h00001111, 32'd3);
    checks++; if (a_valid !== 1'b1 || a_lv !== 4'b1111) begin errors++; $display("FAIL t5_restart_ctl: got v=%b m=%b want 1 1111", a_valid, a_lv); end
    checks++; if (a_msgs[63:0] !== {32'd0, 32'h00001111}) begin errors++; $display("FAIL t5_restart_lane0: got %h want 0000000000001111", a_msgs[63:0]); end
    a_ready = 1'b1;
    step();
    checks++; if (a_done !== 1'b1 || a_valid !== 1'b0) begin errors++; $display("FAIL t5_done: got d=%b v=%b want 1 0", a_done, a_valid); end
    start_a(32'h00002222, 32'd9);
    checks++; if (a_done !== 1'b1 || a_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL t5_start_in_done: got d=%b v=%b b=%b want 1 0 0", a_done, a_valid, a_busy); end
    clear_a();
  endtask

`ifdef MSGGEN_PROGRESS_EN
  // T6a: beat_count counts fires, holds in DONE and clears on clear.
  task automatic test_progress();
    a_ready = 1'b1;
    start_a(32'h55555555, 32'd9);
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_bc !== 32'(k)) begin errors++; $display("FAIL t6_beat_count step%0d: got %0d want %0d", k, a_bc, k); end
      step();
    end
    checks++; if (a_bc !== 32'd3 || a_done !== 1'b1) begin errors++; $display("FAIL t6_hold: got bc=%0d d=%b want 3 1", a_bc, a_done); end
    clear_a();
    checks++; if (a_bc !== 32'd0) begin errors++; $display("FAIL t6_clear: got %0d want 0", a_bc); end
  endtask
`endif

  // T6b: reset asserted mid-run drives every output back to zero.
  task automatic test_reset_midrun();
    a_ready = 1'b0;
    start_a(32'h77777777, 32'd9);
    a_ready = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    checks++; if (a_valid !== 1'b0 || a_lv !== 4'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL t6_rst_ctl: got v=%b m=%b b=%b d=%b want 0 0000 0 0", a_valid, a_lv, a_busy, a_done); end
    checks++; if (a_msgs !== 256'b0) begin errors++; $display("FAIL t6_rst_msgs: got %h want 0", a_msgs[63:0]); end
`ifdef MSGGEN_PROGRESS_EN
    checks++; if (a_bc !== 32'd0) begin errors++; $display("FAIL t6_rst_beat_count: got %0d want 0", a_bc); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_clear = 1'b0; a_ready = 1'b0; a_region = '0; a_limit = '0;
    b_start = 1'b0; b_clear = 1'b0; b_ready = 1'b0; b_region = '0; b_limit = '0;
    #1;
    test_reset();
    test_single_beat();
    test_full_run();
    test_stall();
    test_no_wrap();
    test_clear_restart();
`ifdef MSGGEN_PROGRESS_EN
    test_progress();
`endif
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
